// File: rtl/day3_debounce_edge.sv
// Synchronise a raw single-bit input, debounce it with a qualification FSM and
// emit a clean level, one-cycle edge pulses and a saturating edge count.
module day3_debounce_edge #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             d_i,
    input  logic             en_i,
    input  logic             clr_cnt_i,
    output logic             level_o,
    output logic             rise_o,
    output logic             fall_o,
    output logic             any_edge_o,
    output logic             stable_o,
    output logic [CNT_W-1:0] edge_cnt_o
);

    localparam int QW = 8;
    localparam logic [QW-1:0] QTARGET = QW'(DEBOUNCE_CYCLES);

    typedef enum logic [1:0] {
        ST_LOW,
        ST_QUAL_HIGH,
        ST_HIGH,
        ST_QUAL_LOW
    } state_t;

    state_t                 state;
    logic [QW-1:0]          qcnt;
    logic [QW-1:0]          qcnt_inc;
    logic [SYNC_STAGES-1:0] sync_p;
    logic                   s;
    logic                   rise_hit;
    logic                   fall_hit;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    // synchroniser: plain shift chain, last stage feeds the FSM
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) sync_p <= '0;
        else        sync_p <= {sync_p[SYNC_STAGES-2:0], d_i};
    end

    assign s        = sync_p[SYNC_STAGES-1];
    assign qcnt_inc = qcnt + 1'b1;

    always_comb begin
        rise_hit = 1'b0;
        fall_hit = 1'b0;
        if (en_i) begin
            case (state)
                ST_LOW:       rise_hit = s && (DEBOUNCE_CYCLES == 1);
                ST_QUAL_HIGH: rise_hit = s && (qcnt_inc == QTARGET);
                ST_HIGH:      fall_hit = !s && (DEBOUNCE_CYCLES == 1);
                ST_QUAL_LOW:  fall_hit = !s && (qcnt_inc == QTARGET);
                default: ;
            endcase
        end
    end

    // qualification FSM with registered outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= ST_LOW;
            qcnt       <= '0;
            level_o    <= 1'b0;
            rise_o     <= 1'b0;
            fall_o     <= 1'b0;
            any_edge_o <= 1'b0;
            stable_o   <= 1'b1;
        end else begin
            rise_o     <= rise_hit;
            fall_o     <= fall_hit;
            any_edge_o <= rise_hit | fall_hit;
            if (rise_hit) begin
                state    <= ST_HIGH;
                qcnt     <= '0;
                level_o  <= 1'b1;
                stable_o <= 1'b1;
            end else if (fall_hit) begin
                state    <= ST_LOW;
                qcnt     <= '0;
                level_o  <= 1'b0;
                stable_o <= 1'b1;
            end else begin
                case (state)
                    ST_LOW: begin
                        if (en_i && s) begin
                            state    <= ST_QUAL_HIGH;
                            qcnt     <= 8'd1;
                            stable_o <= 1'b0;
                        end
                    end
                    ST_QUAL_HIGH: begin
                        if (en_i && s) begin
                            qcnt <= qcnt_inc;
                        end else begin
                            state    <= ST_LOW;
                            qcnt     <= '0;
                            stable_o <= 1'b1;
                        end
                    end
                    ST_HIGH: begin
                        if (en_i && !s) begin
                            state    <= ST_QUAL_LOW;
                            qcnt     <= 8'd1;
                            stable_o <= 1'b0;
                        end
                    end
                    ST_QUAL_LOW: begin
                        if (en_i && !s) begin
                            qcnt <= qcnt_inc;
                        end else begin
                            state    <= ST_HIGH;
                            qcnt     <= '0;
                            stable_o <= 1'b1;
                        end
                    end
                    default: begin
                        state    <= ST_LOW;
                        qcnt     <= '0;
                        stable_o <= 1'b1;
                    end
                endcase
            end
        end
    end

    // a clear coinciding with a commit keeps that commit
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            edge_cnt_o <= '0;
        end else if (clr_cnt_i) begin
            edge_cnt_o <= (rise_hit | fall_hit) ? CNT_W'(1) : '0;
        end else if (rise_hit | fall_hit) begin
            edge_cnt_o <= sat_inc(edge_cnt_o);
        end
    end

endmodule

// File: tb/tb_day3_debounce_edge.sv
// Directed scoreboard bench for day3_debounce_edge at default parameters.
module tb_day3_debounce_edge;

    localparam int SYNC = 2;
    localparam int DC   = 4;
    localparam int CW   = 8;

    typedef struct packed {
        logic          level;
        logic          rise;
        logic          fall;
        logic          any;
        logic          stable;
        logic [CW-1:0] cnt;
    } obs_t;

    localparam obs_t RST = {4'b0000, 1'b1, {CW{1'b0}}};

    logic          clk = 1'b0;
    logic          reset;
    logic          d_i;
    logic          en_i;
    logic          clr_cnt_i;
    logic          level_o;
    logic          rise_o;
    logic          fall_o;
    logic          any_edge_o;
    logic          stable_o;
    logic [CW-1:0] edge_cnt_o;

    obs_t sb[$];
    obs_t last;
    logic m_sync[SYNC];
    logic m_level;
    int   m_run;
    int   m_cnt;
    int   tests = 0;
    int   fails = 0;

    day3_debounce_edge #(
        .SYNC_STAGES(SYNC),
        .DEBOUNCE_CYCLES(DC),
        .CNT_W(CW)
    ) dut (
        .clk(clk),
        .reset(reset),
        .d_i(d_i),
        .en_i(en_i),
        .clr_cnt_i(clr_cnt_i),
        .level_o(level_o),
        .rise_o(rise_o),
        .fall_o(fall_o),
        .any_edge_o(any_edge_o),
        .stable_o(stable_o),
        .edge_cnt_o(edge_cnt_o)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    function automatic obs_t observe();
        return {level_o, rise_o, fall_o, any_edge_o, stable_o, edge_cnt_o};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < SYNC; i++) m_sync[i] = 1'b0;
        m_level = 1'b0;
        m_run   = 0;
        m_cnt   = 0;
    endtask

    // run-length model: count consecutive enabled samples disagreeing with level
    task automatic model_edge(input logic d, input logic en, input logic clr, output obs_t e);
        logic s;
        logic commit;
        s      = m_sync[SYNC-1];
        commit = 1'b0;
        if (!en) m_run = 0;
        else if (s != m_level) begin
            m_run++;
            if (m_run == DC) begin
                commit  = 1'b1;
                m_level = s;
                m_run   = 0;
            end
        end else m_run = 0;
        if (clr) m_cnt = commit ? 1 : 0;
        else if (commit && m_cnt < (2**CW) - 1) m_cnt++;
        for (int i = SYNC - 1; i > 0; i--) m_sync[i] = m_sync[i-1];
        m_sync[0] = d;
        e.level  = m_level;
        e.rise   = commit && s;
        e.fall   = commit && !s;
        e.any    = commit;
        e.stable = (m_run == 0);
        e.cnt    = m_cnt[CW-1:0];
    endtask

    task automatic check(input string tag, input obs_t got, input obs_t exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic check_int(input string tag, input int got, input int exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic step(input logic rst, input logic d, input logic en, input logic clr, input string tag);
        obs_t e;
        @(negedge clk);
        reset     = rst;
        d_i       = d;
        en_i      = en;
        clr_cnt_i = clr;
        if (rst) model_edge(d, en, clr, e);
        else begin
            model_reset();
            e = RST;
        end
        sb.push_back(e);
        @(posedge clk);
        #1;
        last = observe();
        check(tag, last, sb.pop_front());
    endtask

    initial begin
        int   rise_at;
        int   fall_at;
        int   pulses;
        logic d;
        reset     = 1'b0;
        d_i       = 1'b1;
        en_i      = 1'b1;
        clr_cnt_i = 1'b0;
        model_reset();

        // 1: reset held with d=1, then release
        repeat (3) step(1'b0, 1'b1, 1'b1, 1'b0, "t1_reset");
        rise_at = 0;
        for (int k = 1; k <= 8; k++) begin
            step(1'b1, 1'b1, 1'b1, 1'b0, "t1_run");
            if (last.rise) rise_at = k;
        end
        check_int("t1_rise_edge", rise_at, 6);
        check_int("t1_cnt", int'(edge_cnt_o), 1);

        // 2: short glitch rejected, 4-cycle pulse accepted
        repeat (8) step(1'b1, 1'b0, 1'b1, 1'b0, "t2_settle");
        pulses = 0;
        repeat (3) step(1'b1, 1'b1, 1'b1, 1'b0, "t2_short");
        for (int k = 0; k < 8; k++) begin
            step(1'b1, 1'b0, 1'b1, 1'b0, "t2_short_tail");
            if (last.any) pulses++;
        end
        check_int("t2_short_pulses", pulses, 0);
        rise_at = 0;
        fall_at = 0;
        for (int k = 1; k <= 14; k++) begin
            step(1'b1, (k <= 4), 1'b1, 1'b0, "t2_long");
            if (last.rise) rise_at = k;
            if (last.fall) fall_at = k;
        end
        check_int("t2_rise_edge", rise_at, 6);
        check_int("t2_fall_edge", fall_at, 10);

        // 3: toggling every cycle never qualifies
        pulses = 0;
        for (int k = 0; k < 40; k++) begin
            step(1'b1, k[0], 1'b1, 1'b0, "t3_toggle");
            if (last.any || last.level) pulses++;
        end
        check_int("t3_pulses", pulses, 0);
        repeat (6) step(1'b1, 1'b0, 1'b1, 1'b0, "t3_settle");

        // 4: disabled qualification, then enable
        repeat (20) step(1'b1, 1'b1, 1'b0, 1'b0, "t4_disabled");
        rise_at = 0;
        for (int k = 1; k <= 6; k++) begin
            step(1'b1, 1'b1, 1'b1, 1'b0, "t4_enable");
            if (last.rise) rise_at = k;
        end
        check_int("t4_rise_edge", rise_at, 4);

        // 5: saturate the edge counter, then clear on a commit
        d = 1'b1;
        for (int i = 0; i < 400 && m_cnt < 255; i++) begin
            d = ~d;
            repeat (5) step(1'b1, d, 1'b1, 1'b0, "t5_preload");
        end
        repeat (6) step(1'b1, d, 1'b1, 1'b0, "t5_preload_tail");
        check_int("t5_sat", int'(edge_cnt_o), 255);
        d = ~d;
        repeat (8) step(1'b1, d, 1'b1, 1'b0, "t5_extra");
        check_int("t5_level_moved", int'(level_o), int'(d));
        check_int("t5_still_sat", int'(edge_cnt_o), 255);
        d = ~d;
        repeat (5) step(1'b1, d, 1'b1, 1'b0, "t5_qual");
        step(1'b1, d, 1'b1, 1'b1, "t5_clr_commit");
        check_int("t5_clr_commit_any", int'(any_edge_o), 1);
        check_int("t5_clr_commit_cnt", int'(edge_cnt_o), 1);
        step(1'b1, d, 1'b1, 1'b1, "t5_clr_plain");
        check_int("t5_clr_plain_cnt", int'(edge_cnt_o), 0);

        // 6: async reset while qualifying low from level 1
        repeat (8) step(1'b1, 1'b1, 1'b1, 1'b0, "t6_high");
        repeat (3) step(1'b1, 1'b0, 1'b1, 1'b0, "t6_qual_low");
        check_int("t6_pre_level", int'(level_o), 1);
        check_int("t6_pre_stable", int'(stable_o), 0);
        #2;
        reset = 1'b0;
        model_reset();
        #1;
        check("t6_async", observe(), RST);
        repeat (2) step(1'b0, 1'b1, 1'b1, 1'b0, "t6_hold");
        rise_at = 0;
        pulses  = 0;
        for (int k = 1; k <= 8; k++) begin
            step(1'b1, 1'b1, 1'b1, 1'b0, "t6_release");
            if (last.rise) rise_at = k;
            if (last.fall) pulses++;
        end
        check_int("t6_rise_edge", rise_at, 6);
        check_int("t6_no_fall", pulses, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/day3_debounce_edge.md
Name: day3_debounce_edge

Overview:
- Downstream consumer of a raw single-bit flop output, such as an unreset or reset-variant DFF q.
- Synchronises the bit into the local clock domain, then debounces it with a qualification counter FSM.
- Emits a clean level plus one-cycle rise, fall and any-edge pulses, and a saturating count of qualified edges.
- Front-end conditioner for button or strobe style inputs feeding the rest of the design.

Parameters:
SYNC_STAGES, 2, synchroniser flop count (legal 2..4)
DEBOUNCE_CYCLES, 4, consecutive identical synchronised samples required to accept a new level (legal 1..255)
CNT_W, 8, width of edge counter

Ports:
clk  input  1  single clock for the whole block
reset  input  1  asynchronous, active-low reset (0 = reset)
d_i  input  1  raw input bit, may be asynchronous and may glitch
en_i  input  1  qualification enable
clr_cnt_i  input  1  synchronous clear of edge_cnt_o
level_o  output  1  debounced level
rise_o  output  1  one-cycle pulse on accepted 0->1
fall_o  output  1  one-cycle pulse on accepted 1->0
any_edge_o  output  1  rise_o | fall_o (registered)
stable_o  output  1  1 when FSM is in a stable state (not qualifying)
edge_cnt_o  output  CNT_W  saturating count of accepted edges

Behaviour:
Reset (reset=0, asynchronous assert; release sampled on clk):
- Synchroniser flops = 0; FSM = ST_LOW; qualification counter = 0.
- level_o=0, rise_o=0, fall_o=0, any_edge_o=0, stable_o=1, edge_cnt_o=0.

Synchroniser:
- SYNC_STAGES-flop shift chain on clk; the last stage is s.
- No logic between stages.

FSM states:
- ST_LOW, ST_QUAL_HIGH, ST_HIGH, ST_QUAL_LOW.

FSM transitions, all on posedge clk:
- ST_LOW with en_i=1 and s=1: go to ST_QUAL_HIGH with qcnt=1. If DEBOUNCE_CYCLES=1, go directly to ST_HIGH and commit.
- ST_QUAL_HIGH with s=1: qcnt++. When the incremented value equals DEBOUNCE_CYCLES, go to ST_HIGH and commit.
- ST_QUAL_HIGH with s=0: return to ST_LOW, qcnt=0, no pulse (glitch rejected).
- ST_HIGH and ST_QUAL_LOW mirror the two rules above with s inverted.
- en_i=0 in either QUAL state: abort to the originating stable state, qcnt=0, no pulse.
- en_i=0 in a stable state: hold.
- The synchroniser always runs regardless of en_i.

Commit (same edge as the transition into the stable state):
- level_o takes the new value.
- rise_o or fall_o = 1 for exactly one cycle; any_edge_o = 1 in the same cycle.
- Outputs are registered and glitch-free.

Latency:
- Take the first edge that samples the new d_i as edge 1.
- level_o and the pulse update on edge SYNC_STAGES+DEBOUNCE_CYCLES, provided d_i stays stable.
- Defaults: edge 6.

Pulses and stable_o:
- No two pulses can occur in consecutive cycles when DEBOUNCE_CYCLES>=2.
- stable_o = 1 in ST_LOW and ST_HIGH, 0 in the QUAL states.

Edge counter:
- Increments on each commit and saturates at 2^CNT_W-1 (no wrap).
- clr_cnt_i=1 with no commit: counter becomes 0 next edge.
- clr_cnt_i=1 with a commit in the same cycle: counter becomes 1, so the event is not lost.

Reset mid-qualification:
- All state is cleared immediately.
- After release, if d_i is held at 1, a full SYNC_STAGES+DEBOUNCE_CYCLES latency elapses, then rise_o pulses, because the level restarts at 0.

Test Plan (defaults SYNC_STAGES=2, DEBOUNCE_CYCLES=4, CNT_W=8):
1. Reset held, d_i=1, then release, en_i=1: level_o=0 until edge 6 after release; then level_o=1, rise_o=1 for 1 cycle, edge_cnt_o=1, stable_o=0 for cycles 3-5.
2. From level 0, d_i=1 for 3 cycles then 0: no rise_o; level_o stays 0; stable_o returns to 1; edge_cnt_o unchanged. Repeat with a 4-cycle pulse: rise_o fires on edge 6, and fall_o fires 4 cycles later.
3. Toggle d_i every cycle for 40 cycles: zero pulses; edge_cnt_o unchanged; level_o constant.
4. en_i=0 with d_i held high for 20 cycles: no commit. Raise en_i: rise_o fires 4 edges later (synchroniser already settled).
5. Preload 255 edges: edge_cnt_o=255 stays at 255 after another commit. Assert clr_cnt_i on a commit cycle: edge_cnt_o=1.
6. Assert reset in ST_QUAL_LOW with level_o=1: outputs go to 0 asynchronously without waiting for clk. No fall_o pulse is emitted.
